music_box_state_controller: RTL and testbench
=============================================

// Module: music_box_state_controller
// PURPOSE
// - Top-level sequencer for the music box user interface. Debounces the four user buttons and owns currentState.
// - currentState is broadcast to every MusicBoxState_* stage module.
// - Consumes each stage's stateComplete flag (generated in the 1 kHz domain) and returns to DoNothing on completion, user abort or timeout.
// PARAMETERS
// - DEBOUNCE_CYCLES  500000      consecutive stable 50 MHz cycles (10 ms) before a button level is accepted
// - TIMEOUT_CYCLES   1500000000  max cycles in any non-idle state (30 s); 0 disables the timeout
// PORTS
// - clock_50Mhz    in   1   sole clock; all logic on posedge
// - reset_n        in   1   asynchronous, active-low reset
// - button_n       in   4   raw, asynchronous, active-low push buttons; bit i selects state i+1
// - stateComplete  in   5   bit s = completion flag of the stage for state s (bit 0 unused); asynchronous to clock_50Mhz
// - currentState   out  5   0=DoNothing 1=PlaySong0 2=PlaySong1 3=PlayRecording 4=MakeRecording
// - debugString    out  32  {exitReason[2:0], currentState[4:0], buttonLevel[3:0], entryCount[19:0]}
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - currentState=0, debugString=0.
//   - All sync flops 1 for button_n, 0 for stateComplete.
//   - Debounced levels=1 (released); all counters=0.
// - Input sync: every button_n and stateComplete bit passes through a 2-flop synchroniser before use.
// - Debounce, per button:
//   - A counter increments while the synced level differs from the debounced level, and clears when they match.
//   - When the counter reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
//   - press[i] is a 1-cycle pulse on a debounced 1->0 transition; releases generate no event.
// - Completion detect:
//   - compEdge[s] is a 1-cycle pulse on a rising edge of synced stateComplete[s].
//   - Level-high alone never counts, so a stale flag still high from a previous visit is ignored.
// - FSM:
//   - DoNothing:
//     - press[i] -> state i+1 on the next edge.
//     - Multiple presses in the same cycle: lowest index wins, others are discarded.
//     - compEdge is ignored.
//   - Active state s:
//     - compEdge[s] -> DoNothing, exitReason=1.
//     - press of own button (bit s-1) -> DoNothing, exitReason=2 (abort).
//     - Presses of other buttons and compEdge of other states are ignored.
//     - TIMEOUT_CYCLES!=0 and the dwell counter reaches TIMEOUT_CYCLES-1 -> DoNothing, exitReason=3.
//     - Simultaneous events: priority is completion > abort > timeout.
// - Dwell counter (32 bit): clears on every state change; increments each cycle in non-idle states; held at 0 in DoNothing.
// - Latency:
//   - press pulse -> currentState updated on the next edge.
//   - stateComplete rise -> currentState=0 on the 4th clock_50Mhz edge (2 sync + edge reg + state reg).
// - debugString:
//   - exitReason holds its last value until the next exit (0 = none since reset).
//   - entryCount increments on each DoNothing->active transition and wraps 0xFFFFF->0.
//   - buttonLevel = inverted debounced levels (1 = pressed).
// - Reset mid-operation: immediate return to DoNothing; downstream stages self-clear on seeing currentState!=own.
// - currentState never changes more than once per clock; no transitions between two active states without passing through 0.
// TESTING (bench params DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100)
// 1. button_n[2] low, glitch high for 2 cycles, then low steady
//    -> one press only; currentState=3 exactly 2+4+1 cycles after the last stable low begins.
// 2. In state 3, raise stateComplete[3]
//    -> currentState=0 on the 4th edge; debugString[31:29]=1; entryCount=1.
// 3. In state 3, hold stateComplete[3] high from before entry, re-press button 2
//    -> stays in 3 (no false exit) until the flag falls and rises again.
// 4. In state 1, press button 0 -> currentState=0, exitReason=2; press button 3 in state 1 -> no change.
// 5. In state 4, no completion -> currentState=0 after exactly 100 cycles, exitReason=3; TIMEOUT_CYCLES=0 -> stays in 4 for 10000 cycles.
// 6. In DoNothing, buttons 1 and 3 debounce in the same cycle -> state 2; assert reset_n=0 in state 2 -> currentState=0 with no clock edge.

Source files
------------

// File: rtl/music_box_state_controller_if.sv
// Button, completion and status signals exchanged with the music box sequencer.
interface music_box_state_controller_if;
  logic [3:0]  button_n;
  logic [4:0]  stateComplete;
  logic [4:0]  currentState;
  logic [31:0] debugString;

  // Stimulus / consumer side
  modport master (
    output button_n,
    output stateComplete,
    input  currentState,
    input  debugString
  );

  // Sequencer side
  modport slave (
    input  button_n,
    input  stateComplete,
    output currentState,
    output debugString
  );
endinterface

// File: rtl/music_box_state_controller.sv
// Music box UI sequencer: debounces the four buttons, owns currentState and
// returns to DoNothing on stage completion, user abort or dwell timeout.
module music_box_state_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TIMEOUT_CYCLES  = 1500000000
) (
  input logic                          clock_50Mhz,
  input logic                          reset_n,
  music_box_state_controller_if.slave  bus
);

  localparam int unsigned NUM_BUTTONS = 4;
  localparam int unsigned DB_W        = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned DWELL_W     = 32;
  localparam int unsigned ENTRY_W     = 20;
  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(TIMEOUT_CYCLES - 1);

  localparam logic [4:0] ST_DO_NOTHING     = 5'd0;
  localparam logic [4:0] ST_PLAY_SONG0     = 5'd1;
  localparam logic [4:0] ST_PLAY_SONG1     = 5'd2;
  localparam logic [4:0] ST_PLAY_RECORDING = 5'd3;
  localparam logic [4:0] ST_MAKE_RECORDING = 5'd4;

  localparam logic [2:0] EXIT_COMPLETE = 3'd1;
  localparam logic [2:0] EXIT_ABORT    = 3'd2;
  localparam logic [2:0] EXIT_TIMEOUT  = 3'd3;

  logic [NUM_BUTTONS-1:0] btn_s1, btn_s2;
  logic [NUM_BUTTONS-1:0] btn_level;
  logic [NUM_BUTTONS-1:0] press_q;
  logic [DB_W-1:0]        db_cnt [NUM_BUTTONS];

  // Bit 0 of stateComplete has no stage behind it, so only bits 4:1 are tracked.
  logic [4:1] sc_s1, sc_s2, sc_s3;
  logic [4:1] comp_edge_q;

  logic [4:0]         state, state_next;
  logic [2:0]         exit_reason, exit_reason_next;
  logic [ENTRY_W-1:0] entry_count, entry_count_next;
  logic [DWELL_W-1:0] dwell, dwell_next;

  logic own_comp_c, own_press_c, timeout_hit_c;

  // Two-flop synchronisers plus the completion rising-edge register
  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1      <= '1;
      btn_s2      <= '1;
      sc_s1       <= '0;
      sc_s2       <= '0;
      sc_s3       <= '0;
      comp_edge_q <= '0;
    end else begin
      btn_s1      <= bus.button_n;
      btn_s2      <= btn_s1;
      sc_s1       <= bus.stateComplete[4:1];
      sc_s2       <= sc_s1;
      sc_s3       <= sc_s2;
      comp_edge_q <= sc_s2 & ~sc_s3;
    end
  end

  // Per-button debounce; a press pulse fires when the accepted level falls
  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      btn_level <= '1;
      press_q   <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        press_q[i] <= 1'b0;
        if (btn_s2[i] != btn_level[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            btn_level[i] <= btn_s2[i];
            db_cnt[i]    <= '0;
            press_q[i]   <= btn_level[i];
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Select the completion edge and abort button belonging to the current state
  always_comb begin
    own_comp_c  = 1'b0;
    own_press_c = 1'b0;
    case (state)
      ST_PLAY_SONG0:     begin own_comp_c = comp_edge_q[1]; own_press_c = press_q[0]; end
      ST_PLAY_SONG1:     begin own_comp_c = comp_edge_q[2]; own_press_c = press_q[1]; end
      ST_PLAY_RECORDING: begin own_comp_c = comp_edge_q[3]; own_press_c = press_q[2]; end
      ST_MAKE_RECORDING: begin own_comp_c = comp_edge_q[4]; own_press_c = press_q[3]; end
      default:           begin own_comp_c = 1'b0;           own_press_c = 1'b0;       end
    endcase
    timeout_hit_c = (TIMEOUT_CYCLES != 0) && (dwell == DWELL_LAST);
  end

  // Next state, exit reason, entry count and dwell counter
  always_comb begin
    state_next       = state;
    exit_reason_next = exit_reason;
    entry_count_next = entry_count;
    dwell_next       = '0;
    if (state == ST_DO_NOTHING) begin
      if (press_q[0])      state_next = ST_PLAY_SONG0;
      else if (press_q[1]) state_next = ST_PLAY_SONG1;
      else if (press_q[2]) state_next = ST_PLAY_RECORDING;
      else if (press_q[3]) state_next = ST_MAKE_RECORDING;
      if (state_next != ST_DO_NOTHING) entry_count_next = entry_count + ENTRY_W'(1);
    end else begin
      if (own_comp_c) begin
        state_next       = ST_DO_NOTHING;
        exit_reason_next = EXIT_COMPLETE;
      end else if (own_press_c) begin
        state_next       = ST_DO_NOTHING;
        exit_reason_next = EXIT_ABORT;
      end else if (timeout_hit_c) begin
        state_next       = ST_DO_NOTHING;
        exit_reason_next = EXIT_TIMEOUT;
      end
      if (state_next == state) dwell_next = dwell + DWELL_W'(1);
    end
  end

  // State and status registers
  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_DO_NOTHING;
      exit_reason <= '0;
      entry_count <= '0;
      dwell       <= '0;
    end else begin
      state       <= state_next;
      exit_reason <= exit_reason_next;
      entry_count <= entry_count_next;
      dwell       <= dwell_next;
    end
  end

  assign bus.currentState = state;
  assign bus.debugString  = {exit_reason, state, ~btn_level, entry_count};

endmodule

// File: tb/tb_music_box_state_controller.sv
// Directed bench for music_box_state_controller with a queue-based scoreboard.
module tb_music_box_state_controller;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  logic [31:0] exp_q[$];

  music_box_state_controller_if bus ();
  music_box_state_controller_if bus0 ();

  music_box_state_controller #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(100)) u_dut (
    .clock_50Mhz (clk),
    .reset_n     (reset_n),
    .bus         (bus.slave)
  );

  music_box_state_controller #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(0)) u_dut_no_timeout (
    .clock_50Mhz (clk),
    .reset_n     (reset_n),
    .bus         (bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
    end
  endtask

  function automatic logic [31:0] st(input logic [31:0] d);
    return 32'(d[28:24]);
  endfunction
  function automatic logic [31:0] xr(input logic [31:0] d);
    return 32'(d[31:29]);
  endfunction
  function automatic logic [31:0] lv(input logic [31:0] d);
    return 32'(d[23:20]);
  endfunction
  function automatic logic [31:0] ec(input logic [31:0] d);
    return 32'(d[19:0]);
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    bus.button_n       = 4'hF;
    bus.stateComplete  = 5'h0;
    bus0.button_n      = 4'hF;
    bus0.stateComplete = 5'h0;

    // Reset state
    push(32'd0); push(32'd0);
    #12;
    check("reset_state", 32'(bus.currentState));
    check("reset_debug", bus.debugString);
    #11 reset_n = 1'b1;
    tick(1);

    // 1: glitchy press of button 2 yields a single entry into state 3
    push(32'd0); push(32'd3); push(32'd4); push(32'd1);
    bus.button_n[2] = 1'b0; tick(3);
    bus.button_n[2] = 1'b1; tick(2);
    bus.button_n[2] = 1'b0; tick(6);
    check("t1_not_yet", 32'(bus.currentState));
    tick(1);
    check("t1_enter", 32'(bus.currentState));
    check("t1_level", lv(bus.debugString));
    check("t1_entries", ec(bus.debugString));
    push(32'd0); push(32'd3);
    bus.button_n[2] = 1'b1; tick(8);
    check("t1_release_level", lv(bus.debugString));
    check("t1_release_state", 32'(bus.currentState));

    // 2: completion flag rise exits on the 4th edge
    push(32'd3); push(32'd0); push(32'd1); push(32'd1);
    bus.stateComplete[3] = 1'b1; tick(3);
    check("t2_edge3", 32'(bus.currentState));
    tick(1);
    check("t2_edge4", 32'(bus.currentState));
    check("t2_exit", xr(bus.debugString));
    check("t2_entries", ec(bus.debugString));
    tick(5);

    // 3: stale high flag does not cause an exit on re-entry
    push(32'd3); push(32'd2); push(32'd3); push(32'd3);
    bus.button_n[2] = 1'b0; tick(7);
    check("t3_enter", 32'(bus.currentState));
    check("t3_entries", ec(bus.debugString));
    bus.button_n[2] = 1'b1; tick(8);
    check("t3_stale_flag", 32'(bus.currentState));
    bus.stateComplete[3] = 1'b0; tick(6);
    check("t3_flag_low", 32'(bus.currentState));
    push(32'd3); push(32'd0); push(32'd1);
    bus.stateComplete[3] = 1'b1; tick(3);
    check("t3_edge3", 32'(bus.currentState));
    tick(1);
    check("t3_edge4", 32'(bus.currentState));
    check("t3_exit", xr(bus.debugString));
    bus.stateComplete[3] = 1'b0; tick(5);

    // 4: own button aborts, other buttons are ignored
    push(32'd1);
    bus.button_n[0] = 1'b0; tick(7);
    check("t4_enter", 32'(bus.currentState));
    bus.button_n[0] = 1'b1; tick(8);
    push(32'd1); push(32'd1);
    bus.button_n[3] = 1'b0; tick(7);
    check("t4_other_press", 32'(bus.currentState));
    bus.button_n[3] = 1'b1; tick(8);
    check("t4_other_release", 32'(bus.currentState));
    push(32'd0); push(32'd2); push(32'd3);
    bus.button_n[0] = 1'b0; tick(7);
    check("t4_abort", 32'(bus.currentState));
    check("t4_exit", xr(bus.debugString));
    check("t4_entries", ec(bus.debugString));
    bus.button_n[0] = 1'b1; tick(8);

    // 5: timeout after exactly 100 cycles in state 4
    push(32'd4); push(32'd4);
    bus.button_n[3] = 1'b0; tick(7);
    check("t5_enter", 32'(bus.currentState));
    check("t5_entries", ec(bus.debugString));
    bus.button_n[3] = 1'b1;
    push(32'd4); push(32'd0); push(32'd3);
    tick(99);
    check("t5_cycle99", 32'(bus.currentState));
    tick(1);
    check("t5_cycle100", 32'(bus.currentState));
    check("t5_exit", xr(bus.debugString));

    // 5b: timeout disabled keeps state 4
    push(32'd4); push(32'd4);
    bus0.button_n[3] = 1'b0; tick(7);
    check("t5b_enter", 32'(bus0.currentState));
    bus0.button_n[3] = 1'b1; tick(10000);
    check("t5b_hold", 32'(bus0.currentState));

    // 6: simultaneous presses pick lowest index; async reset returns to 0
    push(32'd2);
    bus.button_n[1] = 1'b0;
    bus.button_n[3] = 1'b0;
    tick(7);
    check("t6_lowest_wins", 32'(bus.currentState));
    push(32'd0); push(32'd0); push(32'd0);
    #3 reset_n = 1'b0;
    #1;
    check("t6_async_reset", 32'(bus.currentState));
    check("t6_reset_debug", bus.debugString);
    check("t6_reset_other", 32'(bus0.currentState));
    #2 reset_n = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
